writeback_stage: RTL and testbench

Parametrised register-file writeback stage for the pipelined ARM core, sitting after the memory stage and driving the register-file write port and the forwarding network. It registers the MEM/WB boundary and selects the result source among ALU result, load data, and link address (PC + offset). It also waits on a variable-latency memory read response, and aligns and sign/zero-extends sub-word loads. A stall handshake backpressures the memory stage while a load response is outstanding.

---
 rtl/wb_pkg.sv | 23 ++
 rtl/writeback_stage_if.sv | 39 +++
 rtl/wb_load_align.sv | 67 ++++++
 rtl/writeback_stage.sv | 145 ++++++++++++++
 tb/tb_writeback_stage.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared types for the writeback stage: result source, load size, FSM state.
// Imported by writeback_stage and wb_load_align.
package wb_pkg;

  typedef enum logic [1:0] {
    SRC_ALU  = 2'd0,
    SRC_MEM  = 2'd1,
    SRC_LINK = 2'd2
  } src_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_e;

endpackage

// File: rtl/writeback_stage_if.sv
// MEM/WB handshake, load response and register-file write port bundle.
// master = memory stage side, slave = writeback stage.
interface writeback_stage_if #(
  parameter int DATA_W = 64,
  parameter int RA_W   = 5
);

  logic              in_valid;
  logic              in_ready;
  logic              in_we;
  logic [RA_W-1:0]   in_rd;
  logic [1:0]        in_src;
  logic [DATA_W-1:0] in_alu;
  logic [DATA_W-1:0] in_pc;
  logic [1:0]        in_size;
  logic              in_signed;
  logic [2:0]        in_addr_lo;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              wb_en;
  logic [RA_W-1:0]   wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              busy;

  modport master (
    output in_valid, in_we, in_rd, in_src,
    output in_alu, in_pc, in_size, in_signed,
    output in_addr_lo, mem_rvalid, mem_rdata,
    input  in_ready, wb_en, wb_rd, wb_data, busy
  );

  modport slave (
    input  in_valid, in_we, in_rd, in_src,
    input  in_alu, in_pc, in_size, in_signed,
    input  in_addr_lo, mem_rvalid, mem_rdata,
    output in_ready, wb_en, wb_rd, wb_data, busy
  );

endinterface

// File: rtl/wb_load_align.sv
// Sub-word load lane select with zero/sign extension (combinational).
// Used by writeback_stage only when WB_LOAD_EXT_EN is defined.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] rdata,
  input  size_e             size,
  input  logic              sign_ext,
  input  logic [2:0]        addr_lo,
  output logic [DATA_W-1:0] data
);

  localparam logic [DATA_W-1:0] ONES = '1;

  logic              is_b;
  logic              is_h;
  logic              is_w;
  logic              is_d;
  logic [2:0]        lo;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] lane;
  logic              msb;

  // A 32-bit datapath has no dword lanes: size 3 folds into word.
  assign is_b = (size == SZ_B);
  assign is_h = (size == SZ_H);
  assign is_w = (size == SZ_W) ||
                (size == SZ_D && DATA_W == 32);
  assign is_d = (size == SZ_D) && (DATA_W != 32);

  always_comb begin
    lo   = addr_lo;
    mask = ONES;
    if (DATA_W == 32) lo[2] = 1'b0;
    unique case (1'b1)
      is_b: begin
        mask = DATA_W'(8'hFF);
      end
      is_h: begin
        lo[0] = 1'b0;
        mask  = DATA_W'(16'hFFFF);
      end
      is_w: begin
        lo[1:0] = 2'b00;
        mask    = DATA_W'(32'hFFFF_FFFF);
      end
      is_d: begin
        lo   = 3'b000;
        mask = ONES;
      end
      default: begin
        lo   = 3'b000;
        mask = ONES;
      end
    endcase
  end

  // Lane MSB is the highest set bit of the mask.
  assign sh   = rdata >> {lo, 3'b000};
  assign lane = sh & mask;
  assign msb  = |(lane & ~(mask >> 1));
  assign data = (sign_ext && msb) ? (lane | ~mask) : lane;

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB register, result mux and load-response wait FSM.
// Define WB_LOAD_EXT_EN to enable sub-word load extraction.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int RA_W        = 5,
  parameter int ZERO_REG    = 31,
  parameter int LINK_OFFSET = 4
) (
  input logic              clk,
  input logic              rst,
  writeback_stage_if.slave bus
);

  localparam logic [RA_W-1:0]   ZR   = RA_W'(ZERO_REG);
  localparam logic [DATA_W-1:0] LOFF = DATA_W'(LINK_OFFSET);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [RA_W-1:0]   rd_q, rd_d;
  logic              wb_en_q, wb_en_d;
  logic [RA_W-1:0]   wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [DATA_W-1:0] load_val;
  logic              accept;
  logic              is_load;
  logic              resp;

  assign accept  = bus.in_valid && (state_q == IDLE);
  assign is_load = (bus.in_src == SRC_MEM);
  assign resp    = bus.mem_rvalid && (state_q == WAIT_MEM);

`ifdef WB_LOAD_EXT_EN
  size_e      size_q, size_d;
  logic       sgn_q, sgn_d;
  logic [2:0] lo_q, lo_d;

  always_comb begin
    size_d = size_q;
    sgn_d  = sgn_q;
    lo_d   = lo_q;
    if (accept && is_load) begin
      size_d = size_e'(bus.in_size);
      sgn_d  = bus.in_signed;
      lo_d   = bus.in_addr_lo;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      size_q <= SZ_B;
      sgn_q  <= 1'b0;
      lo_q   <= 3'b000;
    end else begin
      size_q <= size_d;
      sgn_q  <= sgn_d;
      lo_q   <= lo_d;
    end
  end

  wb_load_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .rdata    (bus.mem_rdata),
    .size     (size_q),
    .sign_ext (sgn_q),
    .addr_lo  (lo_q),
    .data     (load_val)
  );
`else
  logic unused_ext;

  assign unused_ext = ^{bus.in_size, bus.in_signed, bus.in_addr_lo};
  assign load_val   = bus.mem_rdata;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (accept && is_load) state_d = WAIT_MEM;
      WAIT_MEM: if (resp) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // rd/data only move on a real write so they hold otherwise.
  always_comb begin
    we_d      = we_q;
    rd_d      = rd_q;
    wb_en_d   = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    unique case (1'b1)
      accept && is_load: begin
        we_d = bus.in_we;
        rd_d = bus.in_rd;
      end
      accept && !is_load: begin
        wb_en_d = bus.in_we && (bus.in_rd != ZR);
        if (wb_en_d) begin
          wb_rd_d   = bus.in_rd;
          wb_data_d = (bus.in_src == SRC_LINK) ?
                      bus.in_pc + LOFF : bus.in_alu;
        end
      end
      resp: begin
        wb_en_d = we_q && (rd_q != ZR);
        if (wb_en_d) begin
          wb_rd_d   = rd_q;
          wb_data_d = load_val;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q      <= 1'b0;
      rd_q      <= '0;
      wb_en_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      we_q      <= we_d;
      rd_q      <= rd_d;
      wb_en_q   <= wb_en_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign bus.in_ready = (state_q == IDLE);
  assign bus.busy     = (state_q == WAIT_MEM);
  assign bus.wb_en    = wb_en_q;
  assign bus.wb_rd    = wb_rd_q;
  assign bus.wb_data  = wb_data_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed-vector bench for writeback_stage (DATA_W=64).
// Load expectations follow WB_LOAD_EXT_EN when it is defined.
module tb_writeback_stage;

  logic clk;
  logic rst;
  int   ncmp;
  int   nerr;

  writeback_stage_if #(.DATA_W(64), .RA_W(5)) bus ();

  writeback_stage #(
    .DATA_W      (64),
    .RA_W        (5),
    .ZERO_REG    (31),
    .LINK_OFFSET (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.in_valid   = 1'b0;
    bus.in_we      = 1'b0;
    bus.in_rd      = '0;
    bus.in_src     = 2'd0;
    bus.in_alu     = '0;
    bus.in_pc      = '0;
    bus.in_size    = 2'd0;
    bus.in_signed  = 1'b0;
    bus.in_addr_lo = 3'd0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    ncmp++;
    if (bus.wb_en !== 1'b0) begin
      nerr++;
      $display("FAIL reset_wb_en got=%b exp=0", bus.wb_en);
    end
    ncmp++;
    if (bus.wb_rd !== 5'd0) begin
      nerr++;
      $display("FAIL reset_wb_rd got=%0d exp=0", bus.wb_rd);
    end
    ncmp++;
    if (bus.wb_data !== 64'd0) begin
      nerr++;
      $display("FAIL reset_wb_data got=%h exp=0", bus.wb_data);
    end
    ncmp++;
    if (bus.busy !== 1'b0) begin
      nerr++;
      $display("FAIL reset_busy got=%b exp=0", bus.busy);
    end
    rst = 1'b0;
    tick();
    ncmp++;
    if (bus.in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
    end
  endtask

  task automatic test_alu();
    bus.in_valid = 1'b1;
    bus.in_we    = 1'b1;
    bus.in_src   = 2'd0;
    bus.in_rd    = 5'd3;
    bus.in_alu   = 64'h1234;
    tick();
    idle_inputs();
    ncmp++;
    if (bus.wb_en !== 1'b1 || bus.wb_rd !== 5'd3 ||
        bus.wb_data !== 64'h1234) begin
      nerr++;
      $display("FAIL alu_write got en=%b rd=%0d data=%h exp en=1 rd=3 data=1234",
               bus.wb_en, bus.wb_rd, bus.wb_data);
    end
    tick();
    ncmp++;
    if (bus.wb_en !== 1'b0 || bus.wb_data !== 64'h1234) begin
      nerr++;
      $display("FAIL alu_pulse_hold got en=%b data=%h exp en=0 data=1234",
               bus.wb_en, bus.wb_data);
    end
    // src=3 behaves as ALU
    bus.in_valid = 1'b1;
    bus.in_we    = 1'b1;
    bus.in_src   = 2'd3;
    bus.in_rd    = 5'd9;
    bus.in_alu   = 64'hDEAD;
    bus.in_pc    = 64'h500;
    tick();
    idle_inputs();
    ncmp++;
    if (bus.wb_en !== 1'b1 || bus.wb_rd !== 5'd9 ||
        bus.wb_data !== 64'hDEAD) begin
      nerr++;
      $display("FAIL src3_alu got en=%b rd=%0d data=%h exp en=1 rd=9 data=dead",
               bus.wb_en, bus.wb_rd, bus.wb_data);
    end
    // in_we=0 occupies the stage but does not write
    bus.in_valid = 1'b1;
    bus.in_we    = 1'b0;
    bus.in_rd    = 5'd4;
    bus.in_alu   = 64'h77;
    tick();
    idle_inputs();
    ncmp++;
    if (bus.wb_en !== 1'b0) begin
      nerr++;
      $display("FAIL alu_we0 got en=%b exp en=0", bus.wb_en);
    end
  endtask

  task automatic test_link();
    bus.in_valid = 1'b1;
    bus.in_we    = 1'b1;
    bus.in_src   = 2'd2;
    bus.in_rd    = 5'd30;
    bus.in_pc    = 64'h100;
    bus.in_alu   = 64'hBAD;
    tick();
    idle_inputs();
    ncmp++;
    if (bus.wb_en !== 1'b1 || bus.wb_rd !== 5'd30 ||
        bus.wb_data !== 64'h104) begin
      nerr++;
      $display("FAIL link_write got en=%b rd=%0d data=%h exp en=1 rd=30 data=104",
               bus.wb_en, bus.wb_rd, bus.wb_data);
    end
    bus.in_valid = 1'b1;
    bus.in_we    = 1'b1;
    bus.in_src   = 2'd2;
    bus.in_rd    = 5'd31;
    bus.in_pc    = 64'h200;
    tick();
    idle_inputs();
    ncmp++;
    if (bus.wb_en !== 1'b0) begin
      nerr++;
      $display("FAIL link_xzr got en=%b exp en=0", bus.wb_en);
    end
    // wrap modulo 2^64
    bus.in_valid = 1'b1;
    bus.in_we    = 1'b1;
    bus.in_src   = 2'd2;
    bus.in_rd    = 5'd1;
    bus.in_pc    = 64'hFFFF_FFFF_FFFF_FFFE;
    tick();
    idle_inputs();
    ncmp++;
    if (bus.wb_en !== 1'b1 || bus.wb_data !== 64'h2) begin
      nerr++;
      $display("FAIL link_wrap got en=%b data=%h exp en=1 data=2",
               bus.wb_en, bus.wb_data);
    end
  endtask

  task automatic test_load_signed_byte();
    logic [63:0] exp;
`ifdef WB_LOAD_EXT_EN
    exp = 64'hFFFF_FFFF_FFFF_FF80;
`else
    exp = 64'h0000_8000_0000_0000;
`endif
    bus.in_valid   = 1'b1;
    bus.in_we      = 1'b1;
    bus.in_src     = 2'd1;
    bus.in_rd      = 5'd7;
    bus.in_size    = 2'd0;
    bus.in_signed  = 1'b1;
    bus.in_addr_lo = 3'd5;
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      ncmp++;
      if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.wb_en !== 1'b0) begin
        nerr++;
        $display("FAIL ld_wait%0d got busy=%b rdy=%b en=%b exp 1 0 0",
                 i, bus.busy, bus.in_ready, bus.wb_en);
      end
      // upstream presents a new op that must not be accepted
      bus.in_valid = 1'b1;
      bus.in_we    = 1'b1;
      bus.in_rd    = 5'd12;
      bus.in_alu   = 64'h55;
      if (i == 2) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 64'h0000_8000_0000_0000;
      end
      tick();
    end
    idle_inputs();
    ncmp++;
    if (bus.wb_en !== 1'b1 || bus.wb_rd !== 5'd7 ||
        bus.wb_data !== exp) begin
      nerr++;
      $display("FAIL ld_sbyte got en=%b rd=%0d data=%h exp en=1 rd=7 data=%h",
               bus.wb_en, bus.wb_rd, bus.wb_data, exp);
    end
    ncmp++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL ld_done got busy=%b rdy=%b exp 0 1",
               bus.busy, bus.in_ready);
    end
    tick();
    ncmp++;
    if (bus.wb_en !== 1'b0) begin
      nerr++;
      $display("FAIL ld_no_accept_wait got en=%b exp 0", bus.wb_en);
    end
  endtask

  task automatic load_once(input logic [1:0] sz, input logic sg,
                           input logic [2:0] lo, input logic [63:0] rdata,
                           input logic [4:0] rd);
    bus.in_valid   = 1'b1;
    bus.in_we      = 1'b1;
    bus.in_src     = 2'd1;
    bus.in_rd      = rd;
    bus.in_size    = sz;
    bus.in_signed  = sg;
    bus.in_addr_lo = lo;
    tick();
    idle_inputs();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = rdata;
    tick();
    idle_inputs();
  endtask

  task automatic test_load_sizes();
    logic [63:0] e_h;
    logic [63:0] e_w;
    logic [63:0] rd1;
    logic [63:0] rd2;
    rd1 = 64'h1122_3344_AABB_CCDD;
    rd2 = 64'h8765_4321_0000_0000;
`ifdef WB_LOAD_EXT_EN
    e_h = 64'hAABB;
    e_w = 64'hFFFF_FFFF_8765_4321;
`else
    e_h = rd1;
    e_w = rd2;
`endif
    load_once(2'd1, 1'b0, 3'd3, rd1, 5'd10);
    ncmp++;
    if (bus.wb_en !== 1'b1 || bus.wb_rd !== 5'd10 ||
        bus.wb_data !== e_h) begin
      nerr++;
      $display("FAIL ld_uhalf got en=%b rd=%0d data=%h exp en=1 rd=10 data=%h",
               bus.wb_en, bus.wb_rd, bus.wb_data, e_h);
    end
    load_once(2'd2, 1'b1, 3'd6, rd2, 5'd11);
    ncmp++;
    if (bus.wb_en !== 1'b1 || bus.wb_data !== e_w) begin
      nerr++;
      $display("FAIL ld_sword got en=%b data=%h exp en=1 data=%h",
               bus.wb_en, bus.wb_data, e_w);
    end
    load_once(2'd3, 1'b1, 3'd7, rd2, 5'd12);
    ncmp++;
    if (bus.wb_en !== 1'b1 || bus.wb_data !== rd2) begin
      nerr++;
      $display("FAIL ld_dword got en=%b data=%h exp en=1 data=%h",
               bus.wb_en, bus.wb_data, rd2);
    end
    load_once(2'd3, 1'b0, 3'd0, rd1, 5'd31);
    ncmp++;
    if (bus.wb_en !== 1'b0 || bus.wb_data !== rd2) begin
      nerr++;
      $display("FAIL ld_xzr got en=%b data=%h exp en=0 data=%h",
               bus.wb_en, bus.wb_data, rd2);
    end
  endtask

  task automatic test_reset_mid_load();
    bus.in_valid = 1'b1;
    bus.in_we    = 1'b1;
    bus.in_src   = 2'd1;
    bus.in_rd    = 5'd6;
    tick();
    idle_inputs();
    ncmp++;
    if (bus.busy !== 1'b1) begin
      nerr++;
      $display("FAIL rst_mid_pre got busy=%b exp 1", bus.busy);
    end
    #2;
    rst = 1'b1;
    #1;
    ncmp++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL rst_mid_async got busy=%b rdy=%b exp 0 1",
               bus.busy, bus.in_ready);
    end
    tick();
    rst = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 64'hCAFE;
    tick();
    idle_inputs();
    ncmp++;
    if (bus.wb_en !== 1'b0 || bus.in_ready !== 1'b1 ||
        bus.busy !== 1'b0) begin
      nerr++;
      $display("FAIL rst_mid_drop got en=%b rdy=%b busy=%b exp 0 1 0",
               bus.wb_en, bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      bus.in_valid   = 1'b1;
      bus.in_we      = 1'b1;
      bus.in_src     = 2'd0;
      bus.in_rd      = 5'(i + 1);
      bus.in_alu     = 64'h1000 + 64'(i);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 64'hBEEF;
      tick();
      ncmp++;
      if (bus.wb_en !== 1'b1 || bus.wb_rd !== 5'(i + 1) ||
          bus.wb_data !== 64'h1000 + 64'(i)) begin
        nerr++;
        $display("FAIL b2b_%0d got en=%b rd=%0d data=%h exp en=1 rd=%0d data=%h",
                 i, bus.wb_en, bus.wb_rd, bus.wb_data, i + 1,
                 64'h1000 + 64'(i));
      end
    end
    idle_inputs();
    bus.mem_rvalid = 1'b1;
    tick();
    idle_inputs();
    ncmp++;
    if (bus.wb_en !== 1'b0 || bus.busy !== 1'b0 ||
        bus.wb_data !== 64'h1003) begin
      nerr++;
      $display("FAIL rvalid_idle got en=%b busy=%b data=%h exp 0 0 1003",
               bus.wb_en, bus.busy, bus.wb_data);
    end
  endtask

  initial begin
    ncmp = 0;
    nerr = 0;
    test_reset();
    test_alu();
    test_link();
    test_load_signed_byte();
    test_load_sizes();
    test_reset_mid_load();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
